// File: rtl/mc_mips_ctrl.sv
// mc_mips_ctrl
//
// Control unit for a multicycle MIPS datapath. A Moore state machine walks
// the shared datapath through fetch, decode, execute, memory and writeback.
// It also decodes Funct into the 3-bit ALU control word.
//
// Ports
//   CLK        in   single clock, rising edge
//   RST        in   synchronous active-high reset
//   Op[5:0]    in   opcode from IR[31:26]
//   Funct[5:0] in   function field from IR[5:0]
//   Zero       in   ALU zero flag (combinational)
//   PCEn       out  PC load enable = PCWrite | (Branch & Zero)
//   IorD       out  memory address select (0 PC, 1 ALUOut)
//   MemWrite   out  data memory write enable
//   IRWrite    out  instruction register load enable
//   RegDst     out  register-file A3 select (0 rt, 1 rd)
//   MemtoReg   out  WD3 select (0 ALUOut, 1 memory data)
//   RegWrite   out  register-file write enable
//   ALUSrcA    out  0 PC, 1 register A
//   ALUSrcB    out  00 B, 01 const 4, 10 SignImm, 11 SignImm<<2
//   PCSrc      out  00 ALUResult, 01 ALUOut, 10 jump target
//   ALUControl out  010 add, 110 sub, 000 and, 001 or, 111 slt
//   Illegal    out  sticky flag, set when an unsupported opcode is decoded

module mc_mips_ctrl (
  input  logic       CLK,
  input  logic       RST,
  input  logic [5:0] Op,
  input  logic [5:0] Funct,
  input  logic       Zero,
  output logic       PCEn,
  output logic       IorD,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic       RegDst,
  output logic       MemtoReg,
  output logic       RegWrite,
  output logic       ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] PCSrc,
  output logic [2:0] ALUControl,
  output logic       Illegal
);

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_SLT = 6'b101010;

  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_SLT = 3'b111;

  typedef enum logic [3:0] {
    FETCH,
    DECODE,
    MEMADR,
    MEMRD,
    MEMWB,
    MEMWR,
    EXECUTE,
    ALUWB,
    BRANCH,
    ADDIEX,
    ADDIWB,
    JUMP
  } state_t;

  state_t     state;
  state_t     next_state;
  logic       illegal_q;
  logic       op_legal;

  // Raw per-state enables before reset masking.
  logic       pc_write;
  logic       branch;
  logic       ir_write_raw;
  logic       mem_write_raw;
  logic       reg_write_raw;
  logic [1:0] alu_op;

  // Opcode legality check.
  always_comb begin
    op_legal = 1'b0;
    case (Op)
      OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_ADDI, OP_J: op_legal = 1'b1;
      default:                                       op_legal = 1'b0;
    endcase
  end

  // State register. Reset returns the machine to FETCH at the next edge.
  // This aborts any instruction in flight.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state <= FETCH;
    end else begin
      state <= next_state;
    end
  end

  // Sticky illegal-opcode flag. It is only cleared by reset. It sets on the
  // edge that leaves DECODE with an unsupported opcode.
  always_ff @(posedge CLK) begin
    if (RST) begin
      illegal_q <= 1'b0;
    end else if (state == DECODE && !op_legal) begin
      illegal_q <= 1'b1;
    end
  end

  // Next-state logic.
  always_comb begin
    next_state = FETCH;
    case (state)
      FETCH: next_state = DECODE;
      DECODE: begin
        case (Op)
          OP_LW, OP_SW: next_state = MEMADR;
          OP_RTYPE:     next_state = EXECUTE;
          OP_BEQ:       next_state = BRANCH;
          OP_ADDI:      next_state = ADDIEX;
          OP_J:         next_state = JUMP;
          // An unsupported opcode does not stall the machine.
          default:      next_state = FETCH;
        endcase
      end
      // The load/store split is made from Op as seen in MEMADR.
      MEMADR:  next_state = (Op == OP_LW) ? MEMRD : MEMWR;
      MEMRD:   next_state = MEMWB;
      EXECUTE: next_state = ALUWB;
      ADDIEX:  next_state = ADDIWB;
      MEMWB, MEMWR, ALUWB, BRANCH, ADDIWB, JUMP: next_state = FETCH;
      default: next_state = FETCH;
    endcase
  end

  // Moore output decode. Everything defaults to zero, except the signals
  // that each state drives explicitly.
  always_comb begin
    pc_write      = 1'b0;
    branch        = 1'b0;
    ir_write_raw  = 1'b0;
    mem_write_raw = 1'b0;
    reg_write_raw = 1'b0;
    alu_op        = 2'b00;
    IorD          = 1'b0;
    RegDst        = 1'b0;
    MemtoReg      = 1'b0;
    ALUSrcA       = 1'b0;
    ALUSrcB       = 2'b00;
    PCSrc         = 2'b00;
    case (state)
      FETCH: begin
        ir_write_raw = 1'b1;
        pc_write     = 1'b1;
        ALUSrcB      = 2'b01;
      end
      DECODE: begin
        // This computes the branch target early, in case the instruction
        // turns out to be a beq.
        ALUSrcB = 2'b11;
      end
      MEMADR: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b10;
      end
      MEMRD: begin
        IorD = 1'b1;
      end
      MEMWB: begin
        MemtoReg      = 1'b1;
        reg_write_raw = 1'b1;
      end
      MEMWR: begin
        IorD          = 1'b1;
        mem_write_raw = 1'b1;
      end
      EXECUTE: begin
        ALUSrcA = 1'b1;
        alu_op  = 2'b10;
      end
      ALUWB: begin
        RegDst        = 1'b1;
        reg_write_raw = 1'b1;
      end
      BRANCH: begin
        ALUSrcA = 1'b1;
        alu_op  = 2'b01;
        PCSrc   = 2'b01;
        branch  = 1'b1;
      end
      ADDIEX: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b10;
      end
      ADDIWB: begin
        reg_write_raw = 1'b1;
      end
      JUMP: begin
        PCSrc    = 2'b10;
        pc_write = 1'b1;
      end
      default: begin
        pc_write = 1'b0;
      end
    endcase
  end

  // ALU decoder. This is the only output that looks at Funct.
  // Unknown functs fall back to add and do not raise Illegal.
  always_comb begin
    ALUControl = ALU_ADD;
    case (alu_op)
      2'b00: ALUControl = ALU_ADD;
      2'b01: ALUControl = ALU_SUB;
      2'b10: begin
        case (Funct)
          FN_ADD:  ALUControl = ALU_ADD;
          FN_SUB:  ALUControl = ALU_SUB;
          FN_AND:  ALUControl = ALU_AND;
          FN_OR:   ALUControl = ALU_OR;
          FN_SLT:  ALUControl = ALU_SLT;
          default: ALUControl = ALU_ADD;
        endcase
      end
      default: ALUControl = ALU_ADD;
    endcase
  end

  // While reset is held, every enable is forced low. This keeps the
  // datapath from being written during the cycle where the state register
  // still holds a stale state. Illegal is masked the same way, so it reads
  // as cleared for the whole reset window.
  assign PCEn     = (pc_write | (branch & Zero)) & ~RST;
  assign IRWrite  = ir_write_raw & ~RST;
  assign MemWrite = mem_write_raw & ~RST;
  assign RegWrite = reg_write_raw & ~RST;
  assign Illegal  = illegal_q & ~RST;

endmodule

// File: tb/tb_mc_mips_ctrl.sv
// tb_mc_mips_ctrl
//
// Testbench for mc_mips_ctrl. It compares every cycle of every instruction
// against a reference model. The model describes each instruction as a short
// list of micro-steps, numbered from its FETCH. A table of directed vectors
// also records the key observations, such as cycles per instruction and the
// step where the register file or memory is written.

module tb_mc_mips_ctrl;

  logic       CLK;
  logic       RST;
  logic [5:0] Op;
  logic [5:0] Funct;
  logic       Zero;
  logic       PCEn;
  logic       IorD;
  logic       MemWrite;
  logic       IRWrite;
  logic       RegDst;
  logic       MemtoReg;
  logic       RegWrite;
  logic       ALUSrcA;
  logic [1:0] ALUSrcB;
  logic [1:0] PCSrc;
  logic [2:0] ALUControl;
  logic       Illegal;

  mc_mips_ctrl dut (
    .CLK(CLK),
    .RST(RST),
    .Op(Op),
    .Funct(Funct),
    .Zero(Zero),
    .PCEn(PCEn),
    .IorD(IorD),
    .MemWrite(MemWrite),
    .IRWrite(IRWrite),
    .RegDst(RegDst),
    .MemtoReg(MemtoReg),
    .RegWrite(RegWrite),
    .ALUSrcA(ALUSrcA),
    .ALUSrcB(ALUSrcB),
    .PCSrc(PCSrc),
    .ALUControl(ALUControl),
    .Illegal(Illegal)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  typedef struct packed {
    logic       pcen;
    logic       iord;
    logic       memwrite;
    logic       irwrite;
    logic       regdst;
    logic       memtoreg;
    logic       regwrite;
    logic       alusrca;
    logic [1:0] alusrcb;
    logic [1:0] pcsrc;
    logic [2:0] aluctl;
    logic       illegal;
  } out_t;

  typedef enum int {K_R, K_LW, K_SW, K_BEQ, K_ADDI, K_J, K_BAD} kind_t;

  typedef struct {
    string      name;
    logic [5:0] op;
    logic [5:0] funct;
    int         zmode;
    int         cpi;
    int         rw;
    int         mw;
    int         alu2;
    int         pcen2;
    int         ill;
  } vec_t;

  int   checks;
  int   failures;
  logic model_ill;
  bit   primed;

  // Reference model.
  function automatic kind_t kind_of(logic [5:0] op);
    case (op)
      6'b000000: return K_R;
      6'b100011: return K_LW;
      6'b101011: return K_SW;
      6'b000100: return K_BEQ;
      6'b001000: return K_ADDI;
      6'b000010: return K_J;
      default:   return K_BAD;
    endcase
  endfunction

  function automatic int cpi_of(kind_t k);
    case (k)
      K_LW:              return 5;
      K_SW, K_R, K_ADDI: return 4;
      K_BEQ, K_J:        return 3;
      default:           return 2;
    endcase
  endfunction

  function automatic logic [2:0] funct_alu(logic [5:0] f);
    case (f)
      6'b100000: return 3'b010;
      6'b100010: return 3'b110;
      6'b100100: return 3'b000;
      6'b100101: return 3'b001;
      6'b101010: return 3'b111;
      default:   return 3'b010;
    endcase
  endfunction

  // Step 0 is the instruction's FETCH and step 1 is DECODE. Later steps
  // depend on the instruction kind.
  function automatic out_t model_out(logic [5:0] op, logic [5:0] funct,
                                     logic zero, int step, logic ill);
    out_t  o;
    kind_t k;
    k = kind_of(op);
    o = '0;
    o.aluctl = 3'b010;
    o.illegal = ill;
    if (step == 0 || step >= cpi_of(k)) begin
      o.irwrite = 1'b1;
      o.pcen    = 1'b1;
      o.alusrcb = 2'b01;
    end else if (step == 1) begin
      o.alusrcb = 2'b11;
    end else begin
      case (k)
        K_LW, K_SW: begin
          if (step == 2) begin
            o.alusrca = 1'b1;
            o.alusrcb = 2'b10;
          end else if (k == K_SW) begin
            o.iord     = 1'b1;
            o.memwrite = 1'b1;
          end else if (step == 3) begin
            o.iord = 1'b1;
          end else begin
            o.memtoreg = 1'b1;
            o.regwrite = 1'b1;
          end
        end
        K_R: begin
          if (step == 2) begin
            o.alusrca = 1'b1;
            o.aluctl  = funct_alu(funct);
          end else begin
            o.regdst   = 1'b1;
            o.regwrite = 1'b1;
          end
        end
        K_BEQ: begin
          o.alusrca = 1'b1;
          o.pcsrc   = 2'b01;
          o.aluctl  = 3'b110;
          o.pcen    = zero;
        end
        K_ADDI: begin
          if (step == 2) begin
            o.alusrca = 1'b1;
            o.alusrcb = 2'b10;
          end else begin
            o.regwrite = 1'b1;
          end
        end
        K_J: begin
          o.pcsrc = 2'b10;
          o.pcen  = 1'b1;
        end
        default: o.aluctl = 3'b010;
      endcase
    end
    return o;
  endfunction

  function automatic out_t sample_dut();
    out_t o;
    o.pcen     = PCEn;
    o.iord     = IorD;
    o.memwrite = MemWrite;
    o.irwrite  = IRWrite;
    o.regdst   = RegDst;
    o.memtoreg = MemtoReg;
    o.regwrite = RegWrite;
    o.alusrca  = ALUSrcA;
    o.alusrcb  = ALUSrcB;
    o.pcsrc    = PCSrc;
    o.aluctl   = ALUControl;
    o.illegal  = Illegal;
    return o;
  endfunction

  task automatic applyStimulus(input logic [5:0] op, input logic [5:0] funct,
                               input logic zero);
    Op    = op;
    Funct = funct;
    Zero  = zero;
    #1;
  endtask

  task automatic checkOutput(input string name, input out_t act, input out_t exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic checkInt(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("[TB] FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Runs one instruction. It samples at negedge+1 and compares each step
  // against the model. It stops on the sample that shows the next FETCH, and
  // leaves that cycle "primed" for the following instruction.
  // zmode: 0/1 hold Zero constant, 2 randomises it every cycle.
  task automatic runInstr(input string name, input logic [5:0] op,
                          input logic [5:0] funct, input int zmode,
                          output int cpi, output int rw, output int mw,
                          output int alu2, output int pcen2, output int ill_next);
    out_t got;
    out_t exp;
    logic z;
    cpi = -1; rw = -1; mw = -1; alu2 = -1; pcen2 = -1; ill_next = -1;
    for (int s = 0; s <= 8; s++) begin
      if (s > 0 || !primed) @(negedge CLK);
      z = (zmode == 2) ? 1'($urandom_range(0, 1)) : zmode[0];
      applyStimulus(op, funct, z);
      got = sample_dut();
      if (s > 0 && got.irwrite) begin
        cpi      = s;
        ill_next = int'(got.illegal);
        primed   = 1'b1;
        break;
      end
      exp = model_out(op, funct, z, s, model_ill);
      checkOutput($sformatf("%s.step%0d", name, s), got, exp);
      if (got.regwrite && rw < 0) rw = s;
      if (got.memwrite && mw < 0) mw = s;
      if (s == 2) begin
        alu2  = int'(got.aluctl);
        pcen2 = int'(got.pcen);
      end
      if (s == 1 && kind_of(op) == K_BAD) model_ill = 1'b1;
    end
    if (cpi < 0) begin
      checks++;
      failures++;
      $display("[TB] FAIL %s.timeout: got no FETCH expected FETCH within 8 cycles", name);
      primed = 1'b0;
    end
  endtask

  // lw interrupted by a reset pulse in MEMRD. Illegal is already set on
  // entry and must read as clear once the reset lands.
  task automatic midReset();
    out_t got;
    for (int s = 0; s < 3; s++) begin
      if (s > 0 || !primed) @(negedge CLK);
      applyStimulus(6'b100011, 6'b000000, 1'b0);
      checkOutput($sformatf("rst_lw.step%0d", s), sample_dut(),
                  model_out(6'b100011, 6'b000000, 1'b0, s, model_ill));
    end
    @(negedge CLK);
    RST = 1'b1;
    applyStimulus(6'b100011, 6'b000000, 1'b0);
    got = sample_dut();
    checkInt("rst_lw.memrd_regwrite", int'(got.regwrite), 0);
    checkInt("rst_lw.memrd_memwrite", int'(got.memwrite), 0);
    checkInt("rst_lw.memrd_irwrite", int'(got.irwrite), 0);
    checkInt("rst_lw.memrd_illegal", int'(got.illegal), 0);
    @(negedge CLK);
    RST = 1'b0;
    model_ill = 1'b0;
    applyStimulus(6'b100011, 6'b000000, 1'b0);
    checkOutput("rst_lw.refetch", sample_dut(),
                model_out(6'b100011, 6'b000000, 1'b0, 0, 1'b0));
    primed = 1'b1;
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got no finish expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    vec_t  vecs[$];
    out_t  got;
    out_t  exp;
    int    cpi, rw, mw, alu2, pcen2, ill;
    logic [5:0] legal_ops[6];
    logic [5:0] functs[5];
    logic [5:0] op;
    logic [5:0] fn;

    checks = 0;
    failures = 0;
    model_ill = 1'b0;
    primed = 1'b0;

    vecs.push_back('{"lw",      6'b100011, 6'b000000, 0, 5,  4, -1, 3'b010, 0, 0});
    vecs.push_back('{"sw",      6'b101011, 6'b000000, 0, 4, -1,  3, 3'b010, 0, 0});
    vecs.push_back('{"r_add",   6'b000000, 6'b100000, 0, 4,  3, -1, 3'b010, 0, 0});
    vecs.push_back('{"r_sub",   6'b000000, 6'b100010, 1, 4,  3, -1, 3'b110, 0, 0});
    vecs.push_back('{"r_and",   6'b000000, 6'b100100, 0, 4,  3, -1, 3'b000, 0, 0});
    vecs.push_back('{"r_or",    6'b000000, 6'b100101, 0, 4,  3, -1, 3'b001, 0, 0});
    vecs.push_back('{"r_slt",   6'b000000, 6'b101010, 0, 4,  3, -1, 3'b111, 0, 0});
    vecs.push_back('{"r_unk",   6'b000000, 6'b000000, 0, 4,  3, -1, 3'b010, 0, 0});
    vecs.push_back('{"beq_z1",  6'b000100, 6'b000000, 1, 3, -1, -1, 3'b110, 1, 0});
    vecs.push_back('{"beq_z0",  6'b000100, 6'b000000, 0, 3, -1, -1, 3'b110, 0, 0});
    vecs.push_back('{"addi",    6'b001000, 6'b000000, 0, 4,  3, -1, 3'b010, 0, 0});
    vecs.push_back('{"j",       6'b000010, 6'b000000, 0, 3, -1, -1, 3'b010, 1, 0});
    vecs.push_back('{"illegal", 6'b111111, 6'b000000, 0, 2, -1, -1, -1,    -1, 1});
    vecs.push_back('{"lw_ill",  6'b100011, 6'b000000, 0, 5,  4, -1, 3'b010, 0, 1});

    // Reset held with Op = R-type.
    RST = 1'b1;
    Op = 6'b000000;
    Funct = 6'b000000;
    Zero = 1'b0;
    @(posedge CLK);
    exp = '0;
    exp.alusrcb = 2'b01;
    exp.aluctl = 3'b010;
    for (int i = 0; i < 3; i++) begin
      @(negedge CLK);
      #1;
      got = sample_dut();
      checkOutput($sformatf("reset%0d", i), got, exp);
    end
    @(negedge CLK);
    RST = 1'b0;
    applyStimulus(6'b000000, 6'b000000, 1'b0);
    got = sample_dut();
    checkOutput("release", got, model_out(6'b000000, 6'b000000, 1'b0, 0, 1'b0));
    primed = 1'b1;

    // Directed table.
    foreach (vecs[i]) begin
      runInstr(vecs[i].name, vecs[i].op, vecs[i].funct, vecs[i].zmode,
               cpi, rw, mw, alu2, pcen2, ill);
      checkInt({vecs[i].name, ".cpi"}, cpi, vecs[i].cpi);
      checkInt({vecs[i].name, ".regwrite_step"}, rw, vecs[i].rw);
      checkInt({vecs[i].name, ".memwrite_step"}, mw, vecs[i].mw);
      if (vecs[i].alu2 >= 0) checkInt({vecs[i].name, ".alu_step2"}, alu2, vecs[i].alu2);
      if (vecs[i].pcen2 >= 0) checkInt({vecs[i].name, ".pcen_step2"}, pcen2, vecs[i].pcen2);
      checkInt({vecs[i].name, ".illegal_after"}, ill, vecs[i].ill);
    end

    // Reset pulse in the middle of a load.
    midReset();
    runInstr("addi_after_rst", 6'b001000, 6'b000000, 0, cpi, rw, mw, alu2, pcen2, ill);
    checkInt("addi_after_rst.cpi", cpi, 4);
    checkInt("addi_after_rst.illegal_after", ill, 0);

    // Random instruction stream against the model.
    legal_ops = '{6'b000000, 6'b100011, 6'b101011, 6'b000100, 6'b001000, 6'b000010};
    functs = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010};
    for (int n = 0; n < 60; n++) begin
      if ($urandom_range(0, 7) == 0) op = 6'($urandom);
      else op = legal_ops[$urandom_range(0, 5)];
      if ($urandom_range(0, 5) == 0) fn = 6'($urandom);
      else fn = functs[$urandom_range(0, 4)];
      runInstr($sformatf("rnd%0d", n), op, fn, 2, cpi, rw, mw, alu2, pcen2, ill);
      checkInt($sformatf("rnd%0d.cpi", n), cpi, cpi_of(kind_of(op)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
